bcd_display_scan: RTL

//  Time-multiplexed 7-segment display driver for the BCD counter chain. Takes N packed
//  BCD digits (S3..S0 nibbles per digit), snapshots them once per frame, scans one digit
//  per refresh tick, and drives one-hot anodes plus decoded segments. Sits between the

---
 rtl/bcd_display_scan_pkg.sv | 29 ++
 rtl/bcd_display_scan_bcd_to_7seg.sv | 27 ++
 rtl/bcd_display_scan.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner:
// segment patterns ({g,f,e,d,c,b,a}, active-high) and FSM state encoding.
package bcd_display_scan_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    // Non-BCD nibbles show a dash so a corrupted counter is visible on the board.
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // True when a packed BCD digit is zero (candidate for leading-zero blanking).
    function automatic logic nibble_is_zero(input logic [3:0] nib);
        return (nib == 4'h0);
    endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder; values 10..15 map to a dash.
module bcd_to_7seg
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one nibble.
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver: snapshots NUM_DIGITS packed BCD digits once
// per frame, lights one digit per REFRESH_DIV-cycle slot, optional leading-zero blank.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      CNT_MAX      = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_BASE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tick_s;

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic                    frame_start_q, frame_start_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;

    logic [3:0]              cur_nib_s;
    logic                    run_zero_s;
    logic                    upper_zero_s;
    logic                    blank_s;
    logic                    lit_s;
    logic [6:0]              dec_seg_s;

    assign tick_s = (cnt_q == CNT_MAX);

    // Prescaler next value: free-runs while enabled, held/cleared at 0 otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Select the active snapshot digit and whether it and every higher digit are zero.
    always_comb begin
        cur_nib_s    = 4'h0;
        upper_zero_s = 1'b0;
        run_zero_s   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_zero_s   = run_zero_s & nibble_is_zero(snap_q[4*k +: 4]);
            cur_nib_s    = (index_q == IDX_W'(k)) ? snap_q[4*k +: 4] : cur_nib_s;
            upper_zero_s = (index_q == IDX_W'(k)) ? run_zero_s : upper_zero_s;
        end
    end

    bcd_to_7seg u_dec (
        .nibble_i (cur_nib_s),
        .seg_o    (dec_seg_s)
    );

    // Digit 0 is never blanked so a zero value still shows "0".
    assign blank_s = blank_lz && (index_q != {IDX_W{1'b0}}) && upper_zero_s;
    // Dropping enable darkens the display on the very same edge the FSM leaves SCAN.
    assign lit_s   = (state_q == ST_SCAN) && enable;

    // FSM and output next-state: frame loads, slot advance, blanking and decode.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        snap_d        = snap_q;
        frame_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && tick_s) begin
                    snap_d        = digits_in;
                    index_d       = {IDX_W{1'b0}};
                    frame_start_d = 1'b1;
                    state_d       = ST_SCAN;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    index_d = {IDX_W{1'b0}};
                end else if (tick_s) begin
                    if (index_q == IDX_LAST) begin
                        index_d       = {IDX_W{1'b0}};
                        snap_d        = digits_in;
                        frame_start_d = 1'b1;
                    end else begin
                        index_d       = index_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                index_d = {IDX_W{1'b0}};
            end
        endcase

        if (lit_s) begin
            anode_d = ONE_HOT_BASE << index_q;
            seg_d   = blank_s ? SEG_OFF : dec_seg_s;
        end else begin
            anode_d = {NUM_DIGITS{1'b0}};
            seg_d   = SEG_OFF;
        end
    end

    // FSM state, scan index, frame snapshot and registered display outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            index_q       <= {IDX_W{1'b0}};
            snap_q        <= {(4*NUM_DIGITS){1'b0}};
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            anode_q       <= {NUM_DIGITS{1'b0}};
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            snap_q        <= snap_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
        end
    end

    assign seg         = seg_q;
    assign anode       = anode_q;
    assign frame_start = frame_start_q;

endmodule
